vend_txn_ctrl: RTL and testbench

Transaction sequencer for the vending machine datapath. It accumulates inserted cash into a credit register and accepts a product selection. It checks the selection against the per-product cost and the live inventory counts, then issues a single dispense/inventory-update pulse. Any remaining credit is returned through a valid/ack change handshake. It sits between the coin/keypad front end and the inventory manager.

---
 rtl/vend_txn_ctrl.sv | 177 +++++++++++++++++
 tb/tb_vend_txn_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: collects coin credit, validates a product
// selection against cost and stock, pulses dispense, then returns change
// through a valid/ack handshake. Every output is a flop.
module vend_txn_ctrl #(
  parameter logic [5:0]  COST0          = 6'd15,
  parameter logic [5:0]  COST1          = 6'd20,
  parameter logic [5:0]  COST2          = 6'd25,
  parameter int unsigned MAX_CREDIT     = 63,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [5:0] coin_value,
  output logic       coin_reject,
  input  logic       sel_valid,
  input  logic [1:0] product_sel,
  input  logic       cancel,
  input  logic [3:0] prod1_count,
  input  logic [3:0] prod2_count,
  input  logic [3:0] prod3_count,
  output logic [5:0] credit,
  output logic       dispense,
  output logic [1:0] dispense_sel,
  output logic       update_inventory,
  output logic       change_valid,
  output logic [5:0] change_amount,
  input  logic       change_ack,
  output logic       err_funds,
  output logic       err_soldout,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_DISPENSE,
    S_CHANGE,
    S_REFUND
  } state_t;

  localparam logic [6:0]  MAX_CREDIT7 = 7'(MAX_CREDIT);
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  credit_d;
  logic [15:0] tmo_q, tmo_d;
  logic [1:0]  sel_q, sel_d;
  logic        coin_reject_d, err_funds_d, err_soldout_d;
  logic [6:0]  coin_sum;
  logic [5:0]  cost;
  logic [3:0]  stock;

  // Seven-bit sum so an overflowing coin is detected rather than wrapped.
  assign coin_sum = {1'b0, credit} + {1'b0, coin_value};

  // Price and stock of the latched selection; code 11 shares product 3.
  always_comb begin
    unique case (sel_q)
      2'b00:   begin cost = COST0; stock = prod1_count; end
      2'b01:   begin cost = COST1; stock = prod2_count; end
      default: begin cost = COST2; stock = prod3_count; end
    endcase
  end

  // Next-state, next-credit and pulse decode for the transaction FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    credit_d      = credit;
    tmo_d         = '0;
    sel_d         = sel_q;
    coin_reject_d = 1'b0;
    err_funds_d   = 1'b0;
    err_soldout_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sel_valid) err_funds_d = 1'b1;
        if (coin_valid && coin_value != '0) begin
          if ({1'b0, coin_value} > MAX_CREDIT7) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_value;
            state_d  = S_COLLECT;
          end
        end
      end

      S_COLLECT: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          state_d       = S_REFUND;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          sel_d         = product_sel;
          state_d       = S_CHECK;
        end else if (coin_valid && coin_sum <= MAX_CREDIT7) begin
          // An accepted coin restarts the inactivity window.
          credit_d = coin_sum[5:0];
        end else begin
          coin_reject_d = coin_valid;
          if (tmo_q == TMO_LAST) state_d = S_REFUND;
          else                   tmo_d   = tmo_q + 16'd1;
        end
      end

      S_CHECK: begin
        coin_reject_d = coin_valid;
        // Sold-out outranks insufficient funds.
        if (stock == '0) begin
          err_soldout_d = 1'b1;
          state_d       = S_COLLECT;
        end else if (credit < cost) begin
          err_funds_d = 1'b1;
          state_d     = S_COLLECT;
        end else begin
          state_d = S_DISPENSE;
        end
      end

      S_DISPENSE: begin
        coin_reject_d = coin_valid;
        credit_d      = credit - cost;
        state_d       = (credit != cost) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE, S_REFUND: begin
        coin_reject_d = coin_valid;
        if (change_ack) begin
          credit_d = '0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, credit and registered outputs; outputs decode the next state so
  // they line up with the cycle the FSM is actually in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      credit           <= '0;
      tmo_q            <= '0;
      sel_q            <= '0;
      coin_reject      <= 1'b0;
      err_funds        <= 1'b0;
      err_soldout      <= 1'b0;
      dispense         <= 1'b0;
      update_inventory <= 1'b0;
      dispense_sel     <= '0;
      change_valid     <= 1'b0;
      change_amount    <= '0;
      busy             <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q          <= state_d;
      credit           <= credit_d;
      tmo_q            <= tmo_d;
      sel_q            <= sel_d;
      coin_reject      <= coin_reject_d;
      err_funds        <= err_funds_d;
      err_soldout      <= err_soldout_d;
      dispense         <= (state_d == S_DISPENSE);
      update_inventory <= (state_d == S_DISPENSE);
      dispense_sel     <= (state_d == S_DISPENSE) ? sel_d : 2'b00;
      change_valid     <= (state_d inside {S_CHANGE, S_REFUND});
      change_amount    <= (state_d inside {S_CHANGE, S_REFUND}) ? credit_d : 6'd0;
      busy             <= (state_d inside {S_CHECK, S_DISPENSE, S_CHANGE, S_REFUND});
    end
  end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Bench for vend_txn_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the machine.
module tb_vend_txn_ctrl;

  localparam int MAX_CREDIT = 63;
  localparam int TIMEOUT    = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [5:0] coin_value;
  logic       coin_reject;
  logic       sel_valid;
  logic [1:0] product_sel;
  logic       cancel;
  logic [3:0] prod1_count, prod2_count, prod3_count;
  logic [5:0] credit;
  logic       dispense;
  logic [1:0] dispense_sel;
  logic       update_inventory;
  logic       change_valid;
  logic [5:0] change_amount;
  logic       change_ack;
  logic       err_funds, err_soldout, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: credit held, whether coins are being collected, quiet-cycle
  // count, pending selection under evaluation, a vend in progress, and an
  // outstanding change offer.
  int m_credit, m_idle, m_sel;
  bit m_session, m_vend, m_offer;
  bit e_rej, e_funds, e_sold, e_disp;
  int e_dsel;

  vend_txn_ctrl dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_reject(coin_reject),
    .sel_valid(sel_valid), .product_sel(product_sel), .cancel(cancel),
    .prod1_count(prod1_count), .prod2_count(prod2_count), .prod3_count(prod3_count),
    .credit(credit), .dispense(dispense), .dispense_sel(dispense_sel),
    .update_inventory(update_inventory), .change_valid(change_valid),
    .change_amount(change_amount), .change_ack(change_ack),
    .err_funds(err_funds), .err_soldout(err_soldout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int cost_of(input int s);
    case (s)
      0:       return 15;
      1:       return 20;
      default: return 25;
    endcase
  endfunction

  function automatic int stock_of(input int s);
    case (s)
      0:       return int'(prod1_count);
      1:       return int'(prod2_count);
      default: return int'(prod3_count);
    endcase
  endfunction

  task automatic model_reset();
    m_credit = 0; m_idle = 0; m_sel = -1;
    m_session = 0; m_vend = 0; m_offer = 0;
    e_rej = 0; e_funds = 0; e_sold = 0; e_disp = 0; e_dsel = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented to it.
  task automatic model_step();
    bit took;
    e_rej = 0; e_funds = 0; e_sold = 0; e_disp = 0; e_dsel = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_offer) begin
      e_rej = coin_valid;
      if (change_ack) begin m_credit = 0; m_offer = 0; end
    end else if (m_vend) begin
      e_rej = coin_valid;
      m_credit = m_credit - cost_of(m_sel);
      m_vend = 0; m_sel = -1;
      if (m_credit > 0) m_offer = 1;
    end else if (m_sel >= 0) begin
      e_rej = coin_valid;
      if (stock_of(m_sel) == 0) begin
        e_sold = 1; m_sel = -1; m_idle = 0;
      end else if (m_credit < cost_of(m_sel)) begin
        e_funds = 1; m_sel = -1; m_idle = 0;
      end else begin
        m_vend = 1; m_session = 0; e_disp = 1; e_dsel = m_sel;
      end
    end else if (m_session) begin
      if (cancel) begin
        e_rej = coin_valid; m_session = 0; m_offer = 1;
      end else if (sel_valid) begin
        e_rej = coin_valid; m_sel = int'(product_sel);
      end else begin
        took = 0;
        if (coin_valid) begin
          if (m_credit + int'(coin_value) > MAX_CREDIT) e_rej = 1;
          else begin m_credit += int'(coin_value); m_idle = 0; took = 1; end
        end
        if (!took) begin
          if (m_idle == TIMEOUT - 1) begin m_session = 0; m_offer = 1; m_idle = 0; end
          else m_idle++;
        end
      end
    end else begin
      if (sel_valid) e_funds = 1;
      if (coin_valid && coin_value != 0) begin
        m_credit = int'(coin_value); m_session = 1; m_idle = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("coin_reject",      16'(coin_reject),      16'(e_rej));
    check("err_funds",        16'(err_funds),        16'(e_funds));
    check("err_soldout",      16'(err_soldout),      16'(e_sold));
    check("dispense",         16'(dispense),         16'(e_disp));
    check("update_inventory", 16'(update_inventory), 16'(e_disp));
    check("dispense_sel",     16'(dispense_sel),     16'(e_dsel));
    check("credit",           16'(credit),           16'(m_credit));
    check("change_valid",     16'(change_valid),     16'(m_offer));
    check("change_amount",    16'(change_amount),    16'(m_offer ? m_credit : 0));
    check("busy",             16'(busy),             16'(m_offer || m_vend || m_sel >= 0));
  endtask

  // Present one cycle of inputs, clock it, update the model, compare.
  task automatic step(input bit cv, input logic [5:0] cval, input bit sv,
                      input logic [1:0] ps, input bit cn, input bit ack);
    coin_valid = cv; coin_value = cval; sel_valid = sv;
    product_sel = ps; cancel = cn; change_ack = ack;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    coin_valid = 0; coin_value = '0; sel_valid = 0;
    product_sel = '0; cancel = 0; change_ack = 0;
  endtask

  task automatic coin(input logic [5:0] v); step(1, v, 0, 2'd0, 0, 0); endtask
  task automatic sel(input logic [1:0] p);  step(0, 6'd0, 1, p, 0, 0); endtask
  task automatic nop();                     step(0, 6'd0, 0, 2'd0, 0, 0); endtask
  task automatic ack();                     step(0, 6'd0, 0, 2'd0, 0, 1); endtask

  initial begin
    rst = 0;
    coin_valid = 0; coin_value = '0; sel_valid = 0; product_sel = '0;
    cancel = 0; change_ack = 0;
    prod1_count = 4'd3; prod2_count = 4'd3; prod3_count = 4'd3;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_credit",   16'(credit),       16'd0);
    check("rst_cv",       16'(change_valid), 16'd0);
    check("rst_busy",     16'(busy),         16'd0);
    check("rst_dispense", 16'(dispense),     16'd0);
    rst = 1;

    // Idle: selection without credit, zero-value coin ignored.
    sel(2'd1);
    check("idle_sel_funds", 16'(err_funds), 16'd1);
    coin(6'd0);
    check("idle_zero_coin", 16'(credit), 16'd0);

    // Exact payment: 10+10 for product 01, no change.
    coin(6'd10); coin(6'd10);
    check("t1_credit", 16'(credit), 16'd20);
    sel(2'd1);
    check("t1_busy", 16'(busy), 16'd1);
    nop();
    check("t1_dispense", 16'(dispense),     16'd1);
    check("t1_dsel",     16'(dispense_sel), 16'd1);
    check("t1_upd",      16'(update_inventory), 16'd1);
    nop();
    check("t1_credit0", 16'(credit),       16'd0);
    check("t1_no_cv",   16'(change_valid), 16'd0);

    // Overpayment 30 for product 00, change 15 held until ack.
    coin(6'd20); coin(6'd10); sel(2'd0); nop();
    check("t2_dispense", 16'(dispense), 16'd1);
    nop();
    check("t2_amt", 16'(change_amount), 16'd15);
    nop(); nop();
    check("t2_hold_cv",  16'(change_valid),  16'd1);
    check("t2_hold_amt", 16'(change_amount), 16'd15);
    ack();
    check("t2_cv_clr", 16'(change_valid), 16'd0);
    check("t2_credit", 16'(credit),       16'd0);

    // Insufficient funds, then top up and buy product 10.
    coin(6'd10); sel(2'd2); nop();
    check("t3_err_funds", 16'(err_funds), 16'd1);
    check("t3_credit",    16'(credit),    16'd10);
    coin(6'd20); sel(2'd2); nop(); nop();
    check("t3_amt", 16'(change_amount), 16'd5);
    ack();

    // Sold out outranks funds; then cancel refunds.
    prod1_count = 4'd0;
    coin(6'd30); sel(2'd0); nop();
    check("t4_soldout", 16'(err_soldout), 16'd1);
    check("t4_credit",  16'(credit),      16'd30);
    check("t4_no_disp", 16'(dispense),    16'd0);
    step(0, 6'd0, 0, 2'd0, 1, 0);
    check("t4_refund", 16'(change_amount), 16'd30);
    ack();
    prod1_count = 4'd3;

    // Overflow reject, coin rejected alongside select, reset in CHANGE.
    coin(6'd60); coin(6'd5);
    check("t5_reject", 16'(coin_reject), 16'd1);
    check("t5_credit", 16'(credit),      16'd60);
    step(1, 6'd1, 1, 2'd1, 0, 0);
    check("t5_sel_rej", 16'(coin_reject), 16'd1);
    nop();
    check("t5_disp", 16'(dispense), 16'd1);
    nop();
    check("t5_amt", 16'(change_amount), 16'd40);
    #2 rst = 0;
    #1;
    check("t5_rst_cv",     16'(change_valid),  16'd0);
    check("t5_rst_amt",    16'(change_amount), 16'd0);
    check("t5_rst_credit", 16'(credit),        16'd0);
    check("t5_rst_busy",   16'(busy),          16'd0);
    model_reset();
    nop(); nop();
    rst = 1;

    // Inactivity refund, and a late coin restarting the window.
    coin(6'd5);
    repeat (TIMEOUT - 1) nop();
    check("t6_not_yet", 16'(change_valid), 16'd0);
    nop();
    check("t6_timeout_cv",  16'(change_valid),  16'd1);
    check("t6_timeout_amt", 16'(change_amount), 16'd5);
    ack();
    coin(6'd5);
    repeat (150) nop();
    coin(6'd3);
    repeat (TIMEOUT - 1) nop();
    check("t6_restart_wait", 16'(change_valid), 16'd0);
    nop();
    check("t6_restart_amt", 16'(change_amount), 16'd8);
    ack();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        prod1_count = 4'($urandom_range(0, 3));
        prod2_count = 4'($urandom_range(0, 3));
        prod3_count = 4'($urandom_range(0, 3));
      end
      step($urandom_range(0, 3) == 0, 6'($urandom_range(0, 30)),
           $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
